// File: rtl/joy_scan_ctrl.sv
// joy_scan_ctrl: scans two serial shift-register joystick pads over a shared JOY_CLK/JOY_LOAD pair.
// Optional macro JOY_DEBOUNCE_EN: an output bit only changes when two consecutive scans agree.
module joy_scan_ctrl #(
  parameter int CLK_DIV = 16,
  parameter int LEAD    = 4,
  parameter int NBITS   = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_req,
  output logic        joy_clk,
  output logic        joy_load,
  input  logic        joy_data1,
  input  logic        joy_data2,
  output logic [15:0] joy1,
  output logic [15:0] joy2,
  output logic        valid,
  output logic        busy
);

  localparam int TOTAL = LEAD + NBITS;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW    = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [DW-1:0]    r_div;
  logic             r_loadTick;
  logic [BW-1:0]    r_bit;
  logic             r_pending;
  logic [NBITS-1:0] r_shadow1;
  logic [NBITS-1:0] r_shadow2;
  logic [15:0]      r_joy1;
  logic [15:0]      r_joy2;
  logic             r_valid;
  logic             w_tick;
  logic             w_start;
  logic             w_lastBit;
  logic             w_sample;
  logic [15:0]      w_new1;
  logic [15:0]      w_new2;
  logic [15:0]      w_out1;
  logic [15:0]      w_out2;

  assign w_tick    = (r_div == DW'(CLK_DIV - 1));
  assign w_start   = (r_state == IDLE) && (scan_req || r_pending);
  assign w_lastBit = (r_bit == BW'(TOTAL - 1));
  assign w_sample  = (r_state == SHIFT_HI) && w_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_start) w_next = LOAD;
      LOAD:     if (w_tick && r_loadTick) w_next = SHIFT_LO;
      SHIFT_LO: if (w_tick) w_next = SHIFT_HI;
      SHIFT_HI: if (w_tick) w_next = w_lastBit ? DONE : SHIFT_LO;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    joy_load = (r_state != LOAD);
    joy_clk  = (r_state == SHIFT_HI);
    busy     = (r_state != IDLE);
  end

  // Divider restarts on scan start so the first tick lands exactly CLK_DIV clocks later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_div      <= '0;
      r_loadTick <= 1'b0;
      r_bit      <= '0;
      r_pending  <= 1'b0;
      r_shadow1  <= '1;
      r_shadow2  <= '1;
    end else begin
      r_sync1 <= {r_sync1[0], joy_data1};
      r_sync2 <= {r_sync2[0], joy_data2};
      if (w_start || w_tick) r_div <= '0;
      else                   r_div <= r_div + DW'(1);
      if (w_start)                          r_pending <= 1'b0;
      else if (scan_req && r_state != IDLE) r_pending <= 1'b1;
      if (w_start)                          r_loadTick <= 1'b0;
      else if (r_state == LOAD && w_tick)   r_loadTick <= 1'b1;
      if (w_start)       r_bit <= '0;
      else if (w_sample) r_bit <= r_bit + BW'(1);
      // Bits arrive LSB first, so a right shift leaves the first captured bit at index 0.
      if (w_sample && r_bit >= BW'(LEAD)) begin
        r_shadow1 <= {r_sync1[1], r_shadow1[NBITS-1:1]};
        r_shadow2 <= {r_sync2[1], r_shadow2[NBITS-1:1]};
      end
    end
  end

  always_comb begin
    w_new1 = '1;
    w_new2 = '1;
    w_new1[NBITS-1:0] = r_shadow1;
    w_new2[NBITS-1:0] = r_shadow2;
  end

`ifdef JOY_DEBOUNCE_EN
  logic [15:0] r_prev1;
  logic [15:0] r_prev2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev1 <= '1;
      r_prev2 <= '1;
    end else if (r_state == DONE) begin
      r_prev1 <= w_new1;
      r_prev2 <= w_new2;
    end
  end

  // A bit only follows the new sample when it matches the previous scan's raw value.
  assign w_out1 = (w_new1 & ~(w_new1 ^ r_prev1)) | (r_joy1 & (w_new1 ^ r_prev1));
  assign w_out2 = (w_new2 & ~(w_new2 ^ r_prev2)) | (r_joy2 & (w_new2 ^ r_prev2));
`else
  assign w_out1 = w_new1;
  assign w_out2 = w_new2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_joy1  <= '1;
      r_joy2  <= '1;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == DONE);
      if (r_state == DONE) begin
        r_joy1 <= w_out1;
        r_joy2 <= w_out2;
      end
    end
  end

  assign joy1  = r_joy1;
  assign joy2  = r_joy2;
  assign valid = r_valid;

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// tb_joy_scan_ctrl: directed + randomized bench for joy_scan_ctrl with a behavioural pad model.
// Honours JOY_DEBOUNCE_EN in its reference model when the macro is defined.
module tb_joy_scan_ctrl;

  localparam int CLK_DIV   = 16;
  localparam int LEAD      = 4;
  localparam int NBITS     = 14;
  localparam int SCAN_CLKS = (2 + 2 * (LEAD + NBITS)) * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_req = 1'b0;
  logic        joy_clk;
  logic        joy_load;
  logic        joy_data1;
  logic        joy_data2;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  joy_scan_ctrl #(.CLK_DIV(CLK_DIV), .LEAD(LEAD), .NBITS(NBITS)) dut (
    .clk(clk), .rst_n(rst_n), .scan_req(scan_req),
    .joy_clk(joy_clk), .joy_load(joy_load),
    .joy_data1(joy_data1), .joy_data2(joy_data2),
    .joy1(joy1), .joy2(joy2), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pad model: load presents stream bit 0, each falling joy_clk advances to the next bit.
  logic [13:0] padWord1 = 14'h3FFF;
  logic [13:0] padWord2 = 14'h3FFF;
  logic [3:0]  lead1 = 4'h0;
  logic [3:0]  lead2 = 4'h0;
  int padIdx = 0;

  function automatic logic padBit(logic [3:0] ld, logic [13:0] w, int idx);
    if (idx < LEAD) return ld[idx];
    if (idx < LEAD + NBITS) return w[idx - LEAD];
    return 1'b1;
  endfunction

  always @(negedge joy_clk or negedge joy_load) begin
    if (!joy_load) padIdx = 0;
    else           padIdx = padIdx + 1;
  end

  assign joy_data1 = padBit(lead1, padWord1, padIdx);
  assign joy_data2 = padBit(lead2, padWord2, padIdx);

  int   loadLowCnt, validCnt, monRises, badRise, runLen;
  int   minHi, maxHi, minLo, maxLo;
  logic prevJc = 1'b0;

  always @(negedge clk) begin
    if (joy_load === 1'b0) loadLowCnt++;
    if (valid === 1'b1) validCnt++;
    if (joy_clk !== prevJc) begin
      if (prevJc === 1'b1) begin
        if (runLen < minHi) minHi = runLen;
        if (runLen > maxHi) maxHi = runLen;
      end else if (monRises > 0) begin
        if (runLen < minLo) minLo = runLen;
        if (runLen > maxLo) maxLo = runLen;
      end
      if (joy_clk === 1'b1) begin
        monRises++;
        if (joy_load !== 1'b1) badRise++;
      end
      runLen = 1;
    end else begin
      runLen++;
    end
    prevJc = joy_clk;
  end

  logic [15:0] mOut1 = 16'hFFFF;
  logic [15:0] mOut2 = 16'hFFFF;
  logic [15:0] mPrev1 = 16'hFFFF;
  logic [15:0] mPrev2 = 16'hFFFF;

  function automatic logic [15:0] modelNext(logic [15:0] cur, logic [15:0] prev, logic [15:0] neu);
`ifdef JOY_DEBOUNCE_EN
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[b] = (neu[b] == prev[b]) ? neu[b] : cur[b];
    return r;
`else
    return neu;
`endif
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearStats();
    loadLowCnt = 0; validCnt = 0; monRises = 0; badRise = 0;
    minHi = 100000; maxHi = 0; minLo = 100000; maxLo = 0;
  endtask

  task automatic expectScan(string tag);
    logic [15:0] n1, n2;
    n1 = 16'hC000 | {2'b00, padWord1};
    n2 = 16'hC000 | {2'b00, padWord2};
    mOut1 = modelNext(mOut1, mPrev1, n1);
    mOut2 = modelNext(mOut2, mPrev2, n2);
    mPrev1 = n1;
    mPrev2 = n2;
    checkOutput({tag, "_joy1"}, 32'(joy1), 32'(mOut1));
    checkOutput({tag, "_joy2"}, 32'(joy2), 32'(mOut2));
  endtask

  task automatic applyStimulus();
    @(negedge clk) scan_req = 1'b1;
    @(posedge clk);
    #1 clearStats();
    @(negedge clk) scan_req = 1'b0;
  endtask

  // Counts clocks until valid is seen; gives up after a bound so latency checks catch a hang.
  task automatic waitValid(output int n);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (valid === 1'b1) break;
    end
  endtask

  task automatic doScan(string tag);
    int n;
    applyStimulus();
    waitValid(n);
    checkOutput({tag, "_latency"}, 32'(n), 32'(SCAN_CLKS));
    expectScan(tag);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkOutput("rst_joy1", 32'(joy1), 32'hFFFF);
    checkOutput("rst_joy2", 32'(joy2), 32'hFFFF);
    checkOutput("rst_load", 32'(joy_load), 32'd1);
    checkOutput("rst_clk", 32'(joy_clk), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    padWord1 = 14'h2A55; padWord2 = 14'h15AA;
    lead1 = 4'($urandom); lead2 = 4'($urandom);
    doScan("basic");
`ifndef JOY_DEBOUNCE_EN
    checkOutput("basic_const1", 32'(joy1), 32'hEA55);
    checkOutput("basic_const2", 32'(joy2), 32'hD5AA);
`endif
    checkOutput("rises", 32'(monRises), 32'd18);
    checkOutput("load_low", 32'(loadLowCnt), 32'd32);
    checkOutput("hi_min", 32'(minHi), 32'(CLK_DIV));
    checkOutput("hi_max", 32'(maxHi), 32'(CLK_DIV));
    checkOutput("lo_min", 32'(minLo), 32'(CLK_DIV));
    checkOutput("lo_max", 32'(maxLo), 32'(CLK_DIV));
    checkOutput("load_before_rise", 32'(badRise), 32'd0);
    checkOutput("busy_at_valid", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("valid_one_clk", 32'(valid), 32'd0);

    for (int k = 0; k < 4; k++) begin
      padWord1 = 14'($urandom); padWord2 = 14'($urandom);
      lead1 = 4'($urandom); lead2 = 4'($urandom);
      doScan($sformatf("rand%0d", k));
    end

    // Several requests during one busy scan collapse into a single queued scan.
    padWord1 = 14'($urandom); padWord2 = 14'($urandom);
    applyStimulus();
    for (int p = 0; p < 3; p++) begin
      repeat (49) @(negedge clk);
      scan_req = 1'b1;
      @(negedge clk) scan_req = 1'b0;
    end
    waitValid(n);
    expectScan("pend1");
    checkOutput("pend_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("pend_restart", 32'(busy), 32'd1);
    waitValid(n);
    checkOutput("pend2_latency", 32'(n), 32'(SCAN_CLKS));
    expectScan("pend2");
    repeat (1300) @(negedge clk);
    checkOutput("pend_scan_count", 32'(validCnt), 32'd2);

    padWord1 = 14'($urandom); padWord2 = 14'($urandom);
    @(negedge clk) scan_req = 1'b1;
    @(posedge clk);
    #1 clearStats();
    waitValid(n);
    checkOutput("held1_latency", 32'(n), 32'(SCAN_CLKS));
    expectScan("held1");
    waitValid(n);
    checkOutput("held2_spacing", 32'(n), 32'(SCAN_CLKS + 1));
    expectScan("held2");
    waitValid(n);
    checkOutput("held3_spacing", 32'(n), 32'(SCAN_CLKS + 1));
    expectScan("held3");
    scan_req = 1'b0;
    waitValid(n);
    checkOutput("held_tail_spacing", 32'(n), 32'(SCAN_CLKS + 1));
    expectScan("held_tail");
    repeat (3) @(negedge clk);
    checkOutput("held_idle", 32'(busy), 32'd0);

    padWord1 = 14'($urandom); padWord2 = 14'($urandom);
    applyStimulus();
    repeat (200) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_load", 32'(joy_load), 32'd1);
    checkOutput("mid_rst_clk", 32'(joy_clk), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_joy1", 32'(joy1), 32'hFFFF);
    checkOutput("mid_rst_joy2", 32'(joy2), 32'hFFFF);
    mOut1 = 16'hFFFF; mOut2 = 16'hFFFF; mPrev1 = 16'hFFFF; mPrev2 = 16'hFFFF;
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    checkOutput("mid_rst_no_valid", 32'(validCnt), 32'd0);

    padWord1 = 14'($urandom); padWord2 = 14'($urandom);
    doScan("post_rst");

    // UP button (bit 13): a single-scan press versus a press held across two scans.
    padWord1 = 14'h3FFF; padWord2 = 14'h3FFF;
    doScan("up_base_a");
    doScan("up_base_b");
    padWord1 = 14'h1FFF;
    doScan("up_once");
`ifdef JOY_DEBOUNCE_EN
    checkOutput("up_once_bit", 32'(joy1[13]), 32'd1);
`else
    checkOutput("up_once_bit", 32'(joy1[13]), 32'd0);
`endif
    padWord1 = 14'h3FFF;
    doScan("up_release");
    checkOutput("up_release_bit", 32'(joy1[13]), 32'd1);
    padWord1 = 14'h1FFF;
    doScan("up_hold_a");
    doScan("up_hold_b");
    checkOutput("up_hold_bit", 32'(joy1[13]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
